mem_mp_arb: RTL and testbench

Multi-channel successor to the single-port `mem` block: one WIDTH×DEPTH storage array shared by NUM_CH independent valid/ready request channels. A round-robin arbiter grants at most one channel per cycle. Reads return registered data tagged with the originating channel. The block sits where `mem` sits today, behind one agent per channel in the memory environment.

---
 rtl/mem_mp_arb_pkg.sv | 19 +
 rtl/mem_mp_arb_if.sv | 33 +++
 rtl/mem_rr_arb.sv | 45 ++++
 rtl/mem_mp_arb.sv | 123 ++++++++++++
 tb/tb_mem_mp_arb.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_mp_arb_pkg.sv
// Shared types and defaults for the multi-channel memory (package mem_pkg).
// Optional feature macro used by this block: MEM_PARITY_EN.
package mem_pkg;

    typedef enum logic {READ = 1'b0, WRITE = 1'b1} mem_op_e;

    localparam int MEM_WIDTH      = 8;
    localparam int MEM_DEPTH      = 16;
    localparam int MEM_ADDR_WIDTH = 4;
    localparam int MEM_NUM_CH     = 3;

    // Channel-index width; a single channel still needs a one-bit index.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W = ch_w(MEM_NUM_CH);

endpackage

// File: rtl/mem_mp_arb_if.sv
// Request/response bundle for mem_mp_arb: per-channel valid/ready requests
// plus the single shared read-response path.
interface mem_mp_arb_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CH     = 3
);
    import mem_pkg::*;

    localparam int CW = ch_w(NUM_CH);

    logic [NUM_CH-1:0]            valid_i;
    logic [NUM_CH-1:0]            wr_rd_i;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_CH*WIDTH-1:0]      wr_data_i;
    logic [NUM_CH-1:0]            ready_o;
    logic [WIDTH-1:0]             rd_data_o;
    logic                         rd_valid_o;
    logic [CW-1:0]                rd_ch_o;
    logic                         addr_err_o;
    logic                         rd_err_o;

    modport master (
        output valid_i, wr_rd_i, addr_i, wr_data_i,
        input  ready_o, rd_data_o, rd_valid_o, rd_ch_o, addr_err_o, rd_err_o
    );

    modport slave (
        input  valid_i, wr_rd_i, addr_i, wr_data_i,
        output ready_o, rd_data_o, rd_valid_o, rd_ch_o, addr_err_o, rd_err_o
    );

endinterface

// File: rtl/mem_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, registered priority pointer.
module mem_rr_arb
    import mem_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req,
    output logic [NUM_CH-1:0]       gnt,
    output logic [ch_w(NUM_CH)-1:0] gnt_idx
);
    localparam int CHW = ch_w(NUM_CH);

    logic [CHW-1:0] ptr_reg;
    logic           found;
    int             cand;

    // Scan upward from the pointer with wrap; first requester wins. No grant in reset.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            cand = int'(ptr_reg) + off;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (!found && rst && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = CHW'(cand);
            end
        end
    end

    // Pointer moves just past the granted channel; holds when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= '0;
        end else if (found) begin
            ptr_reg <= (gnt_idx == CHW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_mp_arb.sv
// mem_mp_arb: WIDTH x DEPTH array shared by NUM_CH valid/ready channels
// through a round-robin arbiter; registered, channel-tagged read responses.
// Define MEM_PARITY_EN to store an even-parity bit per word and flag
// mismatches on rd_err_o.
module mem_mp_arb
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int NUM_CH     = MEM_NUM_CH
) (
    input  logic         clk,
    input  logic         rst,
    mem_mp_arb_if.slave  bus
);
    localparam int CHW = ch_w(NUM_CH);
`ifdef MEM_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    logic [NUM_CH-1:0]     gnt;
    logic [CHW-1:0]        gnt_idx;
    logic [ADDR_WIDTH-1:0] ch_addr [NUM_CH];
    logic [WIDTH-1:0]      ch_data [NUM_CH];
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_data;
    mem_op_e               sel_op;
    logic                  any_gnt;
    logic                  in_range;
    logic                  do_wr;
    logic                  do_rd;
    logic [MW-1:0]         wr_word;
    logic [MW-1:0]         rd_word;

    logic [MW-1:0]         mem_q [DEPTH];
    logic [WIDTH-1:0]      rd_data_reg;
    logic                  rd_valid_reg;
    logic [CHW-1:0]        rd_ch_reg;
    logic                  addr_err_reg;

    // Unpack the flat per-channel buses into indexable arrays.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_addr[gi] = bus.addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign ch_data[gi] = bus.wr_data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    mem_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.valid_i),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.ready_o = gnt;
    assign any_gnt     = |gnt;
    assign sel_addr    = ch_addr[gnt_idx];
    assign sel_data    = ch_data[gnt_idx];
    assign sel_op      = mem_op_e'(bus.wr_rd_i[gnt_idx]);
    assign in_range    = 32'(sel_addr) < DEPTH;
    assign do_wr       = any_gnt && (sel_op == WRITE) && in_range;
    assign do_rd       = any_gnt && (sel_op == READ);
    // Out-of-range reads must not touch the array, so the read word is gated to zero.
    assign rd_word     = in_range ? mem_q[sel_addr] : '0;

`ifdef MEM_PARITY_EN
    assign wr_word = {^sel_data, sel_data};
`else
    assign wr_word = sel_data;
`endif

    // Storage array: whole array clears on reset, written on a granted in-range write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_wr) begin
            mem_q[sel_addr] <= wr_word;
        end
    end

    // Response register: one-cycle pulses; data and channel tag update only on reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            rd_ch_reg    <= '0;
            addr_err_reg <= 1'b0;
        end else begin
            rd_valid_reg <= do_rd;
            addr_err_reg <= any_gnt && !in_range;
            if (do_rd) begin
                rd_data_reg <= rd_word[WIDTH-1:0];
                rd_ch_reg   <= gnt_idx;
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic rd_err_reg;

    // Even parity over data+parity must be zero; flag a read whose word is odd.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_err_reg <= 1'b0;
        else      rd_err_reg <= do_rd && in_range && (^rd_word);
    end

    assign bus.rd_err_o = rd_err_reg;
`else
    assign bus.rd_err_o = 1'b0;
`endif

    assign bus.rd_data_o  = rd_data_reg;
    assign bus.rd_valid_o = rd_valid_reg;
    assign bus.rd_ch_o    = rd_ch_reg;
    assign bus.addr_err_o = addr_err_reg;

endmodule

// File: tb/tb_mem_mp_arb.sv
// Directed + randomized bench for mem_mp_arb (DEPTH = 12, three channels),
// checked against a request-level model of the memory and round-robin rule.
`timescale 1ns/1ps
module tb_mem_mp_arb;
    import mem_pkg::*;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 12;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_CH     = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_mp_arb_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_CH(NUM_CH)) bus ();

    mem_mp_arb #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_CH(NUM_CH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model state
    int   model_mem [DEPTH];
    int   ptr;
    int   exp_rd;
    int   obs_gnt;
    // Pending request per channel
    logic rv   [NUM_CH];
    logic rw   [NUM_CH];
    int   ra   [NUM_CH];
    int   rdat [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_CH; i++) begin
            bus.valid_i[i] = rv[i];
            bus.wr_rd_i[i] = rw[i];
            bus.addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(ra[i]);
            bus.wr_data_i[i*WIDTH +: WIDTH]        = WIDTH'(rdat[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 0; rdat[i] = 0;
        end
        ptr = 0;
    endtask

    // Round-robin rule: the requester nearest at-or-after the pointer (mod NUM_CH) wins.
    function automatic int pick();
        int best = -1;
        int bestd = NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rv[i] && ((i - ptr + NUM_CH) % NUM_CH) < bestd) begin
                bestd = (i - ptr + NUM_CH) % NUM_CH;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic req(input int ch, input logic wr, input int addr, input int data);
        rv[ch] = 1'b1; rw[ch] = wr; ra[ch] = addr; rdat[ch] = data;
    endtask

    // One clock: check grant mid-cycle, then the registered response after the edge.
    task automatic cycle(input string tag);
        int   k;
        logic exp_rv;
        logic exp_ae;
        int   exp_ch;
        drive();
        @(negedge clk);
        k = pick();
        obs_gnt = -1;
        for (int i = 0; i < NUM_CH; i++) if (bus.ready_o[i]) obs_gnt = i;
        chk({tag, "_ready"}, 32'(bus.ready_o), (k < 0) ? 32'd0 : (32'd1 << k));
        exp_rv = 1'b0; exp_ae = 1'b0; exp_ch = 0;
        if (k >= 0) begin
            exp_ae = (ra[k] >= DEPTH);
            if (rw[k]) begin
                if (!exp_ae) model_mem[ra[k]] = rdat[k];
            end else begin
                exp_rv = 1'b1;
                exp_ch = k;
                exp_rd = exp_ae ? 0 : model_mem[ra[k]];
            end
            $display("txn %s ch%0d %s addr=%0d wdata=%0h", tag, k, rw[k] ? "WR" : "RD", ra[k], rdat[k]);
            ptr   = (k + 1) % NUM_CH;
            rv[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid_o), 32'(exp_rv));
        chk({tag, "_addr_err"}, 32'(bus.addr_err_o), 32'(exp_ae));
        chk({tag, "_rd_err"},   32'(bus.rd_err_o),   32'd0);
        if (exp_rv) begin
            chk({tag, "_rd_data"}, 32'(bus.rd_data_o), 32'(exp_rd));
            chk({tag, "_rd_ch"},   32'(bus.rd_ch_o),   32'(exp_ch));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ready"},    32'(bus.ready_o),    32'd0);
        chk({tag, "_rd_data"},  32'(bus.rd_data_o),  32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid_o), 32'd0);
        chk({tag, "_rd_ch"},    32'(bus.rd_ch_o),    32'd0);
        chk({tag, "_addr_err"}, 32'(bus.addr_err_o), 32'd0);
        chk({tag, "_rd_err"},   32'(bus.rd_err_o),   32'd0);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            req(a % NUM_CH, 1'b0, a, 0);
            cycle(tag);
        end
    endtask

    int fair_seq [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        // Reset with all channels requesting: no grants, outputs quiet.
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) req(i, 1'b0, i, 0);
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Single channel write then read.
        req(0, 1'b1, 3, 8'hA5); cycle("single_wr");
        req(0, 1'b0, 3, 0);     cycle("single_rd");
        chk("single_rd_data", 32'(bus.rd_data_o), 32'hA5);
        // Bring pointer back to 0 through ch2.
        req(2, 1'b0, 3, 0);     cycle("ch2_rd");

        // Fairness: all three hold reads for six cycles.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NUM_CH; i++) if (!rv[i]) req(i, 1'b0, (c + i) % DEPTH, 0);
            cycle("fair");
            chk("fair_order", 32'(obs_gnt), 32'(fair_seq[c]));
        end
        for (int i = 0; i < NUM_CH; i++) rv[i] = 1'b0;

        // Contention: ch1 write then ch2 read of the same address.
        req(1, 1'b1, 7, 8'h3C);
        req(2, 1'b0, 7, 0);
        cycle("cont_wr");
        chk("cont_first", 32'(obs_gnt), 32'd1);
        cycle("cont_rd");
        chk("cont_second", 32'(obs_gnt), 32'd2);
        chk("cont_data", 32'(bus.rd_data_o), 32'h3C);

        // Out-of-range accesses plus boundary addresses.
        req(0, 1'b1, 13, 8'hFF); cycle("oor_wr");
        req(0, 1'b0, 13, 0);     cycle("oor_rd");
        req(1, 1'b1, DEPTH - 1, 8'h5A); cycle("edge_wr");
        req(1, 1'b0, DEPTH, 0);         cycle("edge_oor_rd");
        req(1, 1'b0, DEPTH - 1, 0);     cycle("edge_rd");
        sweep("oor_sweep");

        // Single channel streaming: granted every cycle.
        for (int c = 0; c < 4; c++) begin
            req(1, 1'b0, c, 0);
            cycle("stream");
            chk("stream_gnt", 32'(obs_gnt), 32'd1);
        end

        // Randomized traffic; requests stay up until granted.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!rv[i] && $urandom_range(0, 2) != 0)
                    req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 255)));
            end
            cycle("rand");
        end
        for (int i = 0; i < NUM_CH; i++) rv[i] = 1'b0;

        // Reset mid-read: response cleared and never reappears.
        req(0, 1'b0, 3, 0);
        drive();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        @(posedge clk);
        #1;
        chk("rst_hold_ready", 32'(bus.ready_o), 32'd0);
        chk("rst_hold_valid", 32'(bus.rd_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        cycle("post_rst");
        sweep("rst_sweep");

`ifdef MEM_PARITY_EN
        // Parity: corrupt one data bit of a stored word and read it back.
        req(0, 1'b1, 2, 8'h01); cycle("par_wr");
        force dut.mem_q[2] = 9'h100;
        #1;
        release dut.mem_q[2];
        req(0, 1'b0, 2, 0);
        drive();
        @(posedge clk);
        #1;
        chk("par_rd_valid", 32'(bus.rd_valid_o), 32'd1);
        chk("par_rd_err",   32'(bus.rd_err_o),   32'd1);
        rv[0] = 1'b0;
        drive();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
